// File: rtl/rgb_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_pkg
//  Description : Shared types and constants for the RGB PWM driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package rgb_pwm_pkg;

    // Driver run state; explicit one-bit encoding.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of colour channels (R, G, B).
    localparam int NUM_CH = 3;

endpackage
`default_nettype wire

// File: rtl/rgb_pwm_driver_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_channel
//  Description : One PWM colour channel. Holds the clamped active duty,
//                compares it against the shared period counter and drives a
//                registered, polarity-adjusted LED pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel #(
    parameter int PWM_INTERVAL = 1200,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int W            = $clog2(PWM_INTERVAL) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] duty_in,
    input  logic         run,
    input  logic [W-1:0] cnt,
    output logic         led
);

    localparam logic [W-1:0] c_DUTY_MAX = W'(PWM_INTERVAL);

    logic [W-1:0] r_active;
    logic [W-1:0] w_clamped;
    logic         w_on;
    logic         r_led;

    // Requests longer than a period would otherwise behave like a full period
    // anyway; clamping keeps the stored value within the documented range.
    assign w_clamped = (duty_in > c_DUTY_MAX) ? c_DUTY_MAX : duty_in;

    // Duty 0 never satisfies cnt < 0; duty PWM_INTERVAL covers every cnt.
    assign w_on = run && (cnt < r_active);

    // Active duty register, updated only at the boundary chosen by the top.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= '0;
        end else if (load) begin
            r_active <= w_clamped;
        end
    end

    // Registered pin so the LED never sees comparator glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led <= ACTIVE_LOW;
        end else begin
            r_led <= w_on ^ ACTIVE_LOW;
        end
    end

    assign led = r_led;

endmodule
`default_nettype wire

// File: rtl/rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_driver
//  Description : Three-channel RGB LED PWM driver. Owns the period counter,
//                the IDLE/RUN state machine and a one-deep pending duty
//                buffer with a valid/ready handshake; new duties take effect
//                at the period boundary (or immediately while idle).
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter  int PWM_INTERVAL = 1200,
    parameter  bit ACTIVE_LOW   = 1'b1,
    localparam int W            = $clog2(PWM_INTERVAL) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         duty_valid,
    output logic         duty_ready,
    input  logic [W-1:0] duty_r,
    input  logic [W-1:0] duty_g,
    input  logic [W-1:0] duty_b,
    output logic         led_r,
    output logic         led_g,
    output logic         led_b,
    output logic         period_start
);

    localparam logic [W-1:0] c_CNT_MAX = W'(PWM_INTERVAL - 1);

    state_t              r_state;
    logic [W-1:0]        r_cnt;
    logic [W-1:0]        w_cnt_next;
    logic                r_period_start;
    logic                r_pend_full;
    logic [W-1:0]        r_pend [NUM_CH];
    logic [W-1:0]        w_duty_in [NUM_CH];
    logic [NUM_CH-1:0]   w_led;
    logic                w_running;
    logic                w_wrap;
    logic                w_xfer;
    logic                w_load_active;

    assign w_duty_in[0] = duty_r;
    assign w_duty_in[1] = duty_g;
    assign w_duty_in[2] = duty_b;

    // Dropping en leaves RUN at the very edge it is sampled, so everything
    // that looks ahead to the next cycle treats RUN-with-en-low as stopped.
    assign w_running = (r_state == RUN) && en;

    // Last cycle of a period; pending duties are promoted at this edge even
    // if en is falling at the same time.
    assign w_wrap = (r_state == RUN) && (r_cnt == c_CNT_MAX);

    assign w_xfer        = duty_valid && !r_pend_full;
    assign w_load_active = r_pend_full && (w_wrap || (r_state == IDLE));

    // Next counter value: step and wrap while running, otherwise park at 0.
    always_comb begin
        w_cnt_next = '0;
        if (w_running && (r_cnt != c_CNT_MAX)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // State machine, period counter and registered period_start pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (en)  r_state <= RUN;
                RUN:     if (!en) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            r_cnt          <= w_cnt_next;
            r_period_start <= en && (w_cnt_next == '0);
        end
    end

    // One-deep pending buffer. Promotion and acceptance never coincide
    // because acceptance requires the buffer to be empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_full <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            if (w_load_active) begin
                r_pend_full <= 1'b0;
            end else if (w_xfer) begin
                r_pend_full <= 1'b1;
            end
            if (w_xfer) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_pend[i] <= w_duty_in[i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        pwm_channel #(
            .PWM_INTERVAL (PWM_INTERVAL),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .W            (W)
        ) u_channel (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (w_load_active),
            .duty_in (r_pend[gi]),
            .run     (w_running),
            .cnt     (r_cnt),
            .led     (w_led[gi])
        );
    end

    assign led_r        = w_led[0];
    assign led_g        = w_led[1];
    assign led_b        = w_led[2];
    assign duty_ready   = !r_pend_full;
    assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_pwm_driver
//  Description : Directed self-checking bench for rgb_pwm_driver with
//                PWM_INTERVAL=10, ACTIVE_LOW=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_pwm_driver;

    localparam int PWM_INTERVAL = 10;
    localparam int W            = $clog2(PWM_INTERVAL) + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         duty_valid;
    logic         duty_ready;
    logic [W-1:0] duty_r;
    logic [W-1:0] duty_g;
    logic [W-1:0] duty_b;
    logic         led_r;
    logic         led_g;
    logic         led_b;
    logic         period_start;

    int n_checks = 0;
    int n_errors = 0;
    int nr, ng, nb;

    rgb_pwm_driver #(
        .PWM_INTERVAL (PWM_INTERVAL),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .duty_r       (duty_r),
        .duty_g       (duty_g),
        .duty_b       (duty_b),
        .led_r        (led_r),
        .led_g        (led_g),
        .led_b        (led_b),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic offer(input int r, input int g, input int b);
        duty_r     = W'(r);
        duty_g     = W'(g);
        duty_b     = W'(b);
        duty_valid = 1'b1;
    endtask

    // Called with cnt==0 current; counts "on" (low) pin cycles over one period.
    task automatic run_period(output int cr, output int cg, output int cb);
        cr = 0; cg = 0; cb = 0;
        for (int i = 0; i < PWM_INTERVAL; i++) begin
            tick();
            if (led_r == 1'b0) cr++;
            if (led_g == 1'b0) cg++;
            if (led_b == 1'b0) cb++;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; duty_valid = 1'b0;
        duty_r = '0; duty_g = '0; duty_b = '0;
        ticks(2);

        // Reset state
        check_eq("rst_leds",  {led_r, led_g, led_b}, 3'b111);
        check_eq("rst_ready", duty_ready, 1);
        check_eq("rst_ps",    period_start, 0);

        // Load (3,0,10) while idle
        rst_n = 1'b1;
        offer(3, 0, 10);
        tick();
        duty_valid = 1'b0;
        check_eq("idle_ready_full", duty_ready, 0);
        tick();
        check_eq("idle_ready_free", duty_ready, 1);

        // Enable: first RUN cycle carries period_start
        en = 1'b1;
        tick();
        check_eq("first_ps", period_start, 1);
        for (int i = 0; i < PWM_INTERVAL; i++) begin
            logic [3:0] exp_v;
            tick();
            exp_v = {(i == PWM_INTERVAL - 1), (i >= 3), 1'b1, 1'b0};
            check_eq($sformatf("p1_c%0d", i), {period_start, led_r, led_g, led_b}, exp_v);
        end

        // Over-range duty clamps to a full period
        offer(15, 0, 10);
        tick();
        duty_valid = 1'b0;
        check_eq("clamp_ready0", duty_ready, 0);
        ticks(8);
        check_eq("clamp_ready_c9", duty_ready, 0);
        tick();
        check_eq("clamp_ready_wrap", duty_ready, 1);
        run_period(nr, ng, nb);
        check_eq("clamp_r", nr, 10);
        check_eq("clamp_g", ng, 0);
        check_eq("clamp_b", nb, 10);

        // Back-to-back offers: A=5 then B=7
        offer(5, 0, 10);
        tick();
        check_eq("b2b_ready_a", duty_ready, 0);
        offer(7, 0, 10);
        ticks(8);
        check_eq("b2b_ready_c9", duty_ready, 0);
        tick();
        check_eq("b2b_ready_wrap", duty_ready, 1);
        tick();
        check_eq("b2b_ready_b", duty_ready, 0);
        duty_valid = 1'b0;
        nr = (led_r == 1'b0) ? 1 : 0;
        for (int i = 1; i < PWM_INTERVAL; i++) begin
            tick();
            if (led_r == 1'b0) nr++;
        end
        check_eq("b2b_a_on", nr, 5);
        run_period(nr, ng, nb);
        check_eq("b2b_b_on", nr, 7);

        // Offer accepted in the cnt==9 cycle: applied one period later
        ticks(9);
        offer(2, 0, 10);
        tick();
        duty_valid = 1'b0;
        check_eq("late_ready0", duty_ready, 0);
        run_period(nr, ng, nb);
        check_eq("late_old_on", nr, 7);
        check_eq("late_ready1", duty_ready, 1);
        run_period(nr, ng, nb);
        check_eq("late_new_on", nr, 2);

        // en dropped at cnt==4 with a pending triple
        offer(4, 0, 10);
        tick();
        duty_valid = 1'b0;
        ticks(3);
        en = 1'b0;
        tick();
        check_eq("endrop_pins", {period_start, led_r, led_g, led_b}, 4'b0111);
        check_eq("endrop_cnt0", dut.r_cnt, 0);
        check_eq("endrop_ready0", duty_ready, 0);
        tick();
        check_eq("endrop_ready1", duty_ready, 1);
        en = 1'b1;
        tick();
        check_eq("reen_ps", period_start, 1);
        run_period(nr, ng, nb);
        check_eq("reen_on", nr, 4);

        // Reset at cnt==6 with pending full discards everything
        offer(8, 8, 8);
        tick();
        duty_valid = 1'b0;
        ticks(5);
        rst_n = 1'b0;
        tick();
        check_eq("mrst_pins", {led_r, led_g, led_b}, 3'b111);
        check_eq("mrst_ready", duty_ready, 1);
        check_eq("mrst_ps", period_start, 0);
        rst_n = 1'b1;
        tick();
        check_eq("mrst_run_ps", period_start, 1);
        run_period(nr, ng, nb);
        check_eq("mrst_all_off", nr + ng + nb, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
